fetch_unit: RTL

- Instruction-fetch stage that sits directly upstream of the instruction decoder.
- Owns the PC and fetches words from instruction memory over a req/ack handshake.
- Holds the fetched word in an instruction register and presents it to decode/execute with a valid/ready handshake.
- When the instruction is consumed, it takes the decoder's `cb` branch code plus the ALU zero flag and computes the next PC.

---
 rtl/fetch_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over imem req/ack, holds the word for decode.
// Optional build macro FETCH_PERF_CNT_EN adds fetch-handshake and fetch-wait counters.

`ifndef NOJUMP
`define NOJUMP 4'b0000
`endif
`ifndef BR_BEQ
`define BR_BEQ 4'b0001
`endif
`ifndef BR_J
`define BR_J   4'b0010
`endif

module fetch_unit #(
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = 32'h0000_3000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  input  logic [3:0]            cb,
  input  logic                  alu_zero
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_wait_cnt
`endif
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [ADDR_WIDTH-1:0]   pc_nxt;
  logic [31:0]             ir;
  logic                    req_q;
  logic                    fetch_done;
  logic                    consume;

  // Branch target: word offset from the immediate, sign-extended and scaled to bytes.
  function automatic logic [ADDR_WIDTH-1:0] branch_target(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [15:0]           imm
  );
    logic signed [ADDR_WIDTH-1:0] offset;
    offset = {{(ADDR_WIDTH-18){imm[15]}}, imm, 2'b00};
    return base + $unsigned(offset);
  endfunction

  // Absolute jump keeps the upper region bits of the sequential address.
  function automatic logic [ADDR_WIDTH-1:0] jump_target(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [25:0]           idx
  );
    return {base[ADDR_WIDTH-1:28], idx, 2'b00};
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_pc(
    input logic [ADDR_WIDTH-1:0] seq,
    input logic [25:0]           ir_lo,
    input logic [3:0]            code,
    input logic                  zero
  );
    logic [ADDR_WIDTH-1:0] npc;
    npc = seq;
    if (code == `BR_BEQ && zero) begin
      npc = branch_target(seq, ir_lo[15:0]);
    end else if (code == `BR_J) begin
      npc = jump_target(seq, ir_lo);
    end
    return npc;
  endfunction

  assign fetch_done = (state == FETCH) && imem_ack;
  assign consume    = (state == HOLD) && instr_ready;
  assign pc_plus4   = pc + PC_STEP;
  assign pc_nxt     = next_pc(pc_plus4, ir[25:0], cb, alu_zero);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (imem_ack)    state_nxt = HOLD;
      HOLD:    if (instr_ready) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      req_q <= 1'b0;
    end else begin
      state <= state_nxt;
      req_q <= (state_nxt == FETCH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      ir <= 32'h0;
    end else begin
      if (consume)    pc <= pc_nxt;
      if (fetch_done) ir <= imem_rdata;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc;
  assign instr       = ir;
  assign instr_valid = (state == HOLD);
  assign pc_out      = pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 32'h0;
      wait_cnt  <= 32'h0;
    end else begin
      if (consume)                         fetch_cnt <= fetch_cnt + 32'd1;
      if ((state == FETCH) && !imem_ack)   wait_cnt  <= wait_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt;
  assign perf_wait_cnt  = wait_cnt;
`endif

endmodule
